// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op codes, byteaccess codes and FSM state shared by the data-memory initiator
package mem_pkg;

   localparam logic [1:0] OP_LH = 2'b00;
   localparam logic [1:0] OP_LB = 2'b01;
   localparam logic [1:0] OP_SH = 2'b10;
   localparam logic [1:0] OP_SB = 2'b11;

   localparam logic [1:0] BA_NONE = 2'b00;
   localparam logic [1:0] BA_RD   = 2'b01;
   localparam logic [1:0] BA_WR   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic logic op_is_half(input logic [1:0] op);
      return (op == OP_LH) || (op == OP_SH);
   endfunction

   function automatic logic op_is_load(input logic [1:0] op);
      return (op == OP_LH) || (op == OP_LB);
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// rtl/mem_load_extend.sv - selects halfword or byte load data and applies sign/zero extension
module mem_load_extend
   import mem_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic        signed_i,
   input  logic [15:0] half_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] rdata_o
);

   always_comb begin
      rdata_o = half_i;
      if (op_i == OP_LB) begin
         rdata_o = signed_i ? {{8{byte_i[7]}}, byte_i} : {8'h00, byte_i};
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - turns single outstanding CPU load/store requests into data_mem strobes
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES    = 20,
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          ALIGN_CHECK  = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write,
   output logic        mem_read,
   output logic [1:0]  mem_byteaccess,
   output logic [31:0] mem_address,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   input  logic [7:0]  mem_data_out_byte
);

   localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               signed_q, signed_d;
   logic [31:0]        addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [32:0]        req_end;
   logic               req_err;
   logic [15:0]        load_data;

   // 33-bit end address so a request near 2^32 cannot wrap into the legal range
   always_comb begin
      req_end = {1'b0, req_addr} + (op_is_half(req_op) ? 33'd2 : 33'd1);
      req_err = (req_end > 33'(MEM_BYTES)) ||
                (ALIGN_CHECK && op_is_half(req_op) && req_addr[0]);
   end

   mem_load_extend u_load_extend (
      .op_i     (op_q),
      .signed_i (signed_q),
      .half_i   (mem_data_out),
      .byte_i   (mem_data_out_byte),
      .rdata_o  (load_data)
   );

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      signed_d       = signed_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      cnt_d          = cnt_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      mem_byteaccess = BA_NONE;
      mem_address    = '0;
      mem_data_in    = '0;

      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d     = req_op;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               err_d    = req_err;
               state_d  = req_err ? S_RESP : S_ISSUE;
            end
         end

         // WAIT only ever holds a load, so the store arms are reached from ISSUE alone
         S_ISSUE, S_WAIT: begin
            mem_address = addr_q;
            unique case (op_q)
               OP_LH: mem_read = 1'b1;
               OP_LB: mem_byteaccess = BA_RD;
               OP_SH: begin
                  mem_write   = 1'b1;
                  mem_data_in = wdata_q;
               end
               default: begin
                  mem_byteaccess = BA_WR;
                  mem_data_in    = {8'h00, wdata_q[7:0]};
               end
            endcase

            if (state_q == S_ISSUE) begin
               if (op_is_load(op_q)) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(1);
               end else begin
                  state_d = S_RESP;
               end
            end else if (cnt_q == CNT_W'(READ_LATENCY)) begin
               rdata_d = load_data;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign resp_rdata = resp_valid ? rdata_q : 16'h0000;
   assign resp_err   = resp_valid & err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_LH;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-array memory model
module tb_mem_access_unit;

   localparam int MEM_BYTES = 20;
   localparam int RL        = 3;

   localparam logic [1:0] LH = 2'b00;
   localparam logic [1:0] LB = 2'b01;
   localparam logic [1:0] SH = 2'b10;
   localparam logic [1:0] SB = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  mem_byteaccess;
   logic [31:0] mem_address;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;
   logic [7:0]  mem_data_out_byte;

   mem_access_unit #(
      .MEM_BYTES    (MEM_BYTES),
      .READ_LATENCY (RL),
      .ALIGN_CHECK  (1'b1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_op            (req_op),
      .req_signed        (req_signed),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_ready        (resp_ready),
      .resp_rdata        (resp_rdata),
      .resp_err          (resp_err),
      .mem_write         (mem_write),
      .mem_read          (mem_read),
      .mem_byteaccess    (mem_byteaccess),
      .mem_address       (mem_address),
      .mem_data_in       (mem_data_in),
      .mem_data_out      (mem_data_out),
      .mem_data_out_byte (mem_data_out_byte)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic        err;
      logic [15:0] rdata;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          run = 0;
   int          strobes = 0;
   bit          seen = 1'b0;
   int          rr_hold = 0;
   bit          mem_init = 1'b1;
   logic [7:0]  ref_mem  [32];
   logic [7:0]  init_mem [32];
   logic [7:0]  phys     [32];
   logic [31:0] garb = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_kind(input logic [1:0] op);
      case (op)
         LH:      return 4'b0100;
         LB:      return 4'b0001;
         SH:      return 4'b1000;
         default: return 4'b0010;
      endcase
   endfunction

   function automatic int exp_lat(input exp_t e);
      if (e.err) return 1;
      return (e.op[1]) ? 2 : 2 + RL;
   endfunction

   function automatic int exp_stb(input exp_t e);
      if (e.err) return 0;
      return (e.op[1]) ? 1 : RL + 1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) garb <= $urandom;

   // Memory side: load data is only valid on the final held strobe cycle, garbage before
   always @(posedge clk) begin
      if (mem_read || mem_byteaccess == 2'b01) run <= run + 1;
      else run <= 0;
      if (mem_init) begin
         for (int i = 0; i < 32; i++) phys[i] <= init_mem[i];
      end else if (!rst) begin
         if (mem_write && mem_address < 32'd19) begin
            phys[mem_address[4:0]]        <= mem_data_in[15:8];
            phys[mem_address[4:0] + 5'd1] <= mem_data_in[7:0];
         end
         if (mem_byteaccess == 2'b10 && mem_address < 32'd20)
            phys[mem_address[4:0]] <= mem_data_in[7:0];
      end
   end

   always_comb begin
      mem_data_out      = garb[15:0];
      mem_data_out_byte = garb[23:16];
      if (mem_read && run == RL && mem_address < 32'd19)
         mem_data_out = {phys[mem_address[4:0]], phys[mem_address[4:0] + 5'd1]};
      if (mem_byteaccess == 2'b01 && run == RL && mem_address < 32'd20)
         mem_data_out_byte = phys[mem_address[4:0]];
   end

   always @(posedge clk) begin
      #1;
      if (rr_hold > 0) begin
         resp_ready = 1'b0;
         rr_hold--;
      end else begin
         resp_ready = ($urandom_range(3) != 0);
      end
   end

   always @(negedge clk) begin
      int nstb;
      if (rst) begin
         strobes = 0;
         seen    = 1'b0;
      end else begin
         nstb = int'(mem_write) + int'(mem_read) + int'(mem_byteaccess != 2'b00);
         chk("strobe_onehot", 32'(nstb <= 1), 32'd1);
         if (nstb != 0) begin
            if (sbq.size() == 0) begin
               chk("strobe_unexpected", 32'(nstb), 32'd0);
            end else begin
               strobes++;
               chk("strobe_kind", {28'h0, mem_write, mem_read, mem_byteaccess}, {28'h0, exp_kind(sbq[0].op)});
               chk("mem_address", mem_address, sbq[0].addr);
               if (sbq[0].op == SH) chk("data_in_sh", {16'h0, mem_data_in}, {16'h0, sbq[0].wdata});
               if (sbq[0].op == SB) chk("data_in_sb", {16'h0, mem_data_in}, {24'h0, sbq[0].wdata[7:0]});
            end
         end else if (req_ready) begin
            chk("idle_address", mem_address, 32'h0);
            chk("idle_data_in", {16'h0, mem_data_in}, 32'h0);
         end
         if (resp_valid) begin
            chk("busy_req_ready", {31'h0, req_ready}, 32'h0);
            if (sbq.size() == 0) begin
               chk("resp_unexpected", {31'h0, resp_valid}, 32'h0);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  chk("latency", 32'(cyc - sbq[0].acc), 32'(exp_lat(sbq[0])));
                  chk("strobe_cycles", 32'(strobes), 32'(exp_stb(sbq[0])));
               end
               chk("resp_rdata", {16'h0, resp_rdata}, {16'h0, sbq[0].rdata});
               chk("resp_err", {31'h0, resp_err}, {31'h0, sbq[0].err});
               if (resp_ready) begin
                  void'(sbq.pop_front());
                  seen    = 1'b0;
                  strobes = 0;
               end
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic issue(input logic [1:0] op, input logic sg, input logic [31:0] a, input logic [15:0] wd);
      exp_t   e;
      int     guard = 0;
      longint size;
      logic [7:0] b;
      req_op = op; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
         @(posedge clk); #1;
         req_valid = 1'b0;
         return;
      end
      size    = op[0] ? 1 : 2;
      e.op    = op;
      e.addr  = a;
      e.wdata = wd;
      e.acc   = cyc;
      e.err   = (longint'(a) + size > longint'(MEM_BYTES)) || (size == 2 && a[0]);
      e.rdata = 16'h0;
      if (!e.err) begin
         case (op)
            LH: e.rdata = {ref_mem[a[4:0]], ref_mem[a[4:0] + 5'd1]};
            LB: begin
               b = ref_mem[a[4:0]];
               e.rdata = (sg && b >= 8'd128) ? 16'hFF00 + 16'(b) : 16'(b);
            end
            SH: begin
               ref_mem[a[4:0]]        = wd[15:8];
               ref_mem[a[4:0] + 5'd1] = wd[7:0];
            end
            default: ref_mem[a[4:0]] = wd[7:0];
         endcase
      end
      sbq.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = 16'($urandom);
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (!(sbq.size() == 0 && req_ready) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_timeout", 32'(sbq.size() == 0 && req_ready), 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) begin
         init_mem[i] = 8'($urandom);
         ref_mem[i]  = init_mem[i];
      end
      init_mem[1] = 8'hDC;
      ref_mem[1]  = 8'hDC;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_strobes", {28'h0, mem_write, mem_read, mem_byteaccess}, 32'h0);
      chk("rst_address", mem_address, 32'h0);
      chk("rst_data_in", {16'h0, mem_data_in}, 32'h0);
      chk("rst_rdata_err", {15'h0, resp_rdata, resp_err}, 32'h0);
      mem_init = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      issue(SH, 1'b0, 32'd4, 16'h1342);
      issue(LB, 1'b1, 32'd1, 16'h0000);
      issue(LB, 1'b0, 32'd1, 16'h0000);
      issue(LH, 1'b0, 32'd19, 16'h0000);
      issue(LH, 1'b0, 32'd3, 16'h0000);
      issue(LH, 1'b1, 32'd4, 16'h0000);
      issue(SB, 1'b0, 32'hFFFF_FFFF, 16'h1234);
      issue(LH, 1'b0, 32'd18, 16'h0000);

      wait_idle();
      rr_hold = 12;
      issue(SB, 1'b0, 32'd10, 16'hAB77);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("held_resp_valid", {31'h0, resp_valid}, 32'h1);
         chk("held_req_ready", {31'h0, req_ready}, 32'h0);
      end
      @(posedge clk); #1;
      issue(LB, 1'b0, 32'd10, 16'h0000);
      issue(LH, 1'b0, 32'd6, 16'h0000);

      wait_idle();
      issue(LH, 1'b0, 32'd6, 16'h0000);
      @(posedge clk); #1;
      chk("wait_read_held", {31'h0, mem_read}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_mid_strobes", {28'h0, mem_write, mem_read, mem_byteaccess}, 32'h0);
      chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
         chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
      end
      @(posedge clk); #1;

      for (int n = 0; n < 300; n++) begin
         op = 2'($urandom_range(3));
         if ($urandom_range(9) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(3));
         else a = 32'($urandom_range(21));
         issue(op, 1'($urandom), a, 16'($urandom));
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
      end

      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
